weight_bank_streamer: RTL

Parametrised weight store for the ANN datapath: NUM_BANKS independent block-RAM banks of DEPTH x DATA_W words, loaded word by word through a host write port. A read engine streams addresses 0..len-1 from all banks in parallel, one beat per address. Each beat is NUM_BANKS weights wide and is delivered on a valid/ready output with backpressure, last-beat and done indications. It replaces per-neuron single-bank weight memories: one instance feeds a whole group of multiply-accumulate lanes.

---
 rtl/weight_mem_pkg.sv | 22 ++
 rtl/weight_bank_ram.sv | 34 +++
 rtl/weight_bank_streamer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/weight_mem_pkg.sv
// Shared constants and types for the weight bank streamer.
package weight_mem_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_DEPTH     = 28;
    localparam int DEF_NUM_BANKS = 4;

    // Stream engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One output beat in the default configuration
    typedef struct packed {
        logic [DEF_NUM_BANKS*DEF_DATA_W-1:0] data;
        logic [$clog2(DEF_DEPTH)-1:0]        addr;
        logic                                last;
    } beat_t;

endpackage

// File: rtl/weight_bank_ram.sv
// Single weight bank: DEPTH x DATA_W block RAM, one write port and one
// synchronous read-first read port. Contents are not reset.
module weight_bank_ram
    import weight_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port and registered read port; read data holds when not enabled
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/weight_bank_streamer.sv
// NUM_BANKS parallel weight banks with a host write port and a read engine
// that streams addresses 0..len-1 as valid/ready beats NUM_BANKS words wide.
module weight_bank_streamer
    import weight_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          wr_en,
    input  logic [BANK_W-1:0]             wr_bank,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    output logic                          busy,
    output logic                          err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_BANKS*DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]             out_addr,
    output logic                          out_last,
    output logic                          done
);

    localparam int BEAT_W = NUM_BANKS * DATA_W;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } lane_beat_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rd_ptr;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_if_addr;
    logic              r_if_last;
    lane_beat_t        r_buf [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;
    logic              r_err;
    logic              r_done;

    logic              w_wr_ok;
    logic              w_len_ok;
    logic              w_start_ok;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_occ;
    logic              w_done_nxt;
    logic [BEAT_W-1:0] w_ram_data;
    lane_beat_t        w_bypass;
    lane_beat_t        w_head;

    assign w_wr_ok = wr_en && (r_state == IDLE)
                   && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH))
                   && ({1'b0, wr_bank} < (BANK_W+1)'(NUM_BANKS));

    assign w_len_ok   = (len != '0) && (len <= LEN_W'(DEPTH));
    assign w_start_ok = (r_state == IDLE) && start && w_len_ok;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            weight_bank_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_bank (
                .i_clk     (CLK),
                .i_wr_en   (w_wr_ok && (wr_bank == BANK_W'(b))),
                .i_wr_addr (wr_addr),
                .i_wr_data (wr_data),
                .i_rd_en   (w_issue),
                .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
                .o_rd_data (w_ram_data[b*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // The RAM read register acts as a bypass stage in front of the FIFO so
    // that an empty buffer costs no extra cycle of latency.
    assign w_bypass  = '{data: w_ram_data, addr: r_if_addr, last: r_if_last};
    assign w_head    = (r_count != 2'd0) ? r_buf[r_head] : w_bypass;
    assign out_valid = (r_count != 2'd0) || r_inflight;
    assign out_data  = out_valid ? w_head.data : '0;
    assign out_addr  = out_valid ? w_head.addr : '0;
    assign out_last  = out_valid && w_head.last;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign done      = r_done;

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight && !((r_count == 2'd0) && out_ready);
    // Buffered beats after this edge; a new read may only be issued if its
    // data is guaranteed a free slot.
    assign w_occ  = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

    assign w_last_issue = (r_rd_ptr == (r_len - LEN_W'(1)));
    assign w_issue      = (r_state == RUN) && (w_occ < 2'd2);

    // Next-state decode and done pulse request
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_issue && w_last_issue) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_occ == 2'd0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stream counters, in-flight read tracking and status pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_len      <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_if_addr  <= '0;
            r_if_last  <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len    <= len;
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + LEN_W'(1);
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_addr <= r_rd_ptr[ADDR_W-1:0];
                r_if_last <= w_last_issue;
            end
            r_err  <= (r_state == IDLE) && start && !w_len_ok;
            r_done <= w_done_nxt;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop && (r_count != 2'd0)) begin
                r_head <= ~r_head;
            end
            r_count <= w_occ;
        end
    end

    // Output FIFO storage
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_buf[r_tail] <= w_bypass;
        end
    end

endmodule
